// File: rtl/handshake_arbiter.sv
// handshake_arbiter: round-robin sharing of one 4-phase req/ack datapath stage among N_REQ requesters.
// Define HS_SYNC_EN to pass req_in and stage_ack through 2-flop synchronizers.
module handshake_arbiter #(
  parameter  int WIDTH = 8,
  parameter  int N_REQ = 4,
  localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_in,
  output logic [N_REQ-1:0]       ack_in,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]       res_out,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   stage_req,
  input  logic                   stage_ack,
  output logic [WIDTH-1:0]       stage_din,
  input  logic [WIDTH-1:0]       stage_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RELEASE,
    S_RESP
  } state_e;

  logic [N_REQ-1:0] req_s;
  logic             stage_ack_s;

`ifdef HS_SYNC_EN
  logic [N_REQ-1:0] req_meta_q;
  logic [N_REQ-1:0] req_sync_q;
  logic             ack_meta_q;
  logic             ack_sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_meta_q <= '0;
      req_sync_q <= '0;
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      req_meta_q <= req_in;
      req_sync_q <= req_meta_q;
      ack_meta_q <= stage_ack;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign req_s       = req_sync_q;
  assign stage_ack_s = ack_sync_q;
`else
  assign req_s       = req_in;
  assign stage_ack_s = stage_ack;
`endif

  state_e            state_q,     state_d;
  logic [GW-1:0]     ptr_q,       ptr_d;
  logic [GW-1:0]     grant_id_q,  grant_id_d;
  logic [WIDTH-1:0]  stage_din_q, stage_din_d;
  logic [WIDTH-1:0]  res_out_q,   res_out_d;
  logic [N_REQ-1:0]  ack_in_q,    ack_in_d;
  logic              busy_q,      busy_d;
  logic              stage_req_q, stage_req_d;

  // Round-robin search starting just after the last winner. Scanning from the
  // farthest candidate back towards ptr+1 leaves the highest-priority hit last.
  logic          any_req;
  logic [GW-1:0] winner;
  logic [GW:0]   cand;

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req_s[cand[GW-1:0]]) begin
        any_req = 1'b1;
        winner  = cand[GW-1:0];
      end
    end
  end

  // NOTE: every signal gets a hold default before the case so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_id_d  = grant_id_q;
    stage_din_d = stage_din_q;
    res_out_d   = res_out_q;
    ack_in_d    = ack_in_q;
    busy_d      = busy_q;
    stage_req_d = stage_req_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_id_d  = winner;
          stage_din_d = data_in[winner*WIDTH +: WIDTH];
          busy_d      = 1'b1;
          stage_req_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (stage_ack_s) begin
          res_out_d   = stage_dout;
          stage_req_d = 1'b0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Ack to the requester only once the stage has fully returned to zero.
        if (!stage_ack_s) begin
          ack_in_d             = '0;
          ack_in_d[grant_id_q] = 1'b1;
          state_d              = S_RESP;
        end
      end
      S_RESP: begin
        if (!req_s[grant_id_q]) begin
          ack_in_d = '0;
          ptr_d    = grant_id_q;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= GW'(N_REQ - 1);
      grant_id_q  <= '0;
      stage_din_q <= '0;
      res_out_q   <= '0;
      ack_in_q    <= '0;
      busy_q      <= 1'b0;
      stage_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id_q  <= grant_id_d;
      stage_din_q <= stage_din_d;
      res_out_q   <= res_out_d;
      ack_in_q    <= ack_in_d;
      busy_q      <= busy_d;
      stage_req_q <= stage_req_d;
    end
  end

  assign ack_in    = ack_in_q;
  assign res_out   = res_out_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign stage_req = stage_req_q;
  assign stage_din = stage_din_q;

  a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack_in_q));
  a_ack_excl:   assert property (@(posedge clk) disable iff (!rst_n) !(stage_req_q && (|ack_in_q)));

endmodule

// File: tb/tb_handshake_arbiter.sv
// Bench for handshake_arbiter: randomized requesters and a 4-phase stage model, with a
// scoreboard fed by a round-robin reference model and drained by an independent monitor.
module tb_handshake_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int GW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_in;
  logic [N-1:0]   ack_in;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   res_out;
  logic [GW-1:0]  grant_id;
  logic           busy;
  logic           stage_req;
  logic           stage_ack;
  logic [W-1:0]   stage_din;
  logic [W-1:0]   stage_dout;

  int n_checks;
  int n_fail;

  typedef struct {
    int         winner;
    logic [W-1:0] din;
    logic [W-1:0] res;
  } exp_t;

  exp_t sb[$];
  int   model_ptr;
  int   stage_delay_fixed;
  int   last_winner;

  // monitor / stage-model state
  logic [N-1:0] mon_prev_ack;
  exp_t         mon_e;
  int           st_phase;
  int           st_cnt;
  logic [W-1:0] st_cap;

  handshake_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .ack_in     (ack_in),
    .data_in    (data_in),
    .res_out    (res_out),
    .grant_id   (grant_id),
    .busy       (busy),
    .stage_req  (stage_req),
    .stage_ack  (stage_ack),
    .stage_din  (stage_din),
    .stage_dout (stage_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: first pending requester after the last winner, cyclically.
  function automatic int rr_pick(input int p, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (p + k) % N;
      if ((pend & (N'(1) << idx)) != '0) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs_zero();
    check("rst_ack_in",    ack_in,    0);
    check("rst_res_out",   res_out,   0);
    check("rst_grant_id",  grant_id,  0);
    check("rst_busy",      busy,      0);
    check("rst_stage_req", stage_req, 0);
    check("rst_stage_din", stage_din, 0);
  endtask

  task automatic wait_busy(input logic val, input string name);
    int c;
    c = 0;
    while (busy !== val && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(name, busy, val);
  endtask

  task automatic wait_ack(input logic nonzero, input string name);
    int c;
    c = 0;
    while ((ack_in != '0) !== nonzero && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(name, ack_in != '0, nonzero);
  endtask

  // Asserts reset from a negedge, checks outputs clear before any clock edge, then releases.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_outputs_zero();
    req_in = '0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = N - 1;
    sb.delete();
    @(negedge clk);
  endtask

  // One full transaction for whoever the model says wins.
  task automatic serve(input bit mod_data, input bit reraise, input logic [N-1:0] add_mask,
                       input bit early_drop);
    int           w;
    exp_t         e;
    logic [N-1:0] new_bits;
    w = rr_pick(model_ptr, req_in);
    if (w < 0) return;
    e.winner = w;
    e.din    = data_in[w*W +: W];
    e.res    = e.din + W'(1);
    sb.push_back(e);
    model_ptr = w;
    wait_busy(1'b1, "grant_busy");
    if (mod_data) data_in[w*W +: W] = W'($urandom);
    new_bits = add_mask & ~req_in;
    for (int i = 0; i < N; i++)
      if ((new_bits & (N'(1) << i)) != '0) data_in[i*W +: W] = W'($urandom);
    req_in = req_in | new_bits;
    if (early_drop) req_in = req_in & ~(N'(1) << w);
    wait_ack(1'b1, "ack_rise");
    if (early_drop) begin
      @(negedge clk);
      check("ack_pulse_1clk", ack_in, 0);
    end
    req_in = req_in & ~(N'(1) << w);
    wait_ack(1'b0, "ack_fall");
    if (reraise) begin
      data_in[w*W +: W] = W'($urandom);
      req_in = req_in | (N'(1) << w);
    end
  endtask

  // Stage model: 4-phase responder returning din+1, tolerant of an early stage_req drop.
  initial begin
    stage_ack  = 1'b0;
    stage_dout = '0;
    st_phase   = 0;
    st_cnt     = 0;
    st_cap     = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stage_ack = 1'b0;
        st_phase  = 0;
      end else begin
        case (st_phase)
          0: if (stage_req) begin
               st_cap     = stage_din;
               stage_dout = W'($urandom);
               st_cnt     = (stage_delay_fixed >= 0) ? stage_delay_fixed : int'($urandom_range(0, 3));
               st_phase   = 1;
             end
          1: begin
               check("stage_req_hold", stage_req, 1);
               check("stage_din_stable", stage_din, st_cap);
               if (st_cnt == 0) begin
                 stage_dout = st_cap + W'(1);
                 stage_ack  = 1'b1;
                 st_phase   = 2;
               end else st_cnt--;
             end
          2: if (!stage_req) begin
               st_cnt   = int'($urandom_range(0, 3));
               st_phase = 3;
             end else check("stage_din_stable", stage_din, st_cap);
          default: if (st_cnt == 0) begin
                     stage_ack = 1'b0;
                     st_phase  = 0;
                   end else st_cnt--;
        endcase
      end
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each ack_in rise.
  initial begin
    mon_prev_ack = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_ack = '0;
      end else begin
        check("ack_onehot", $onehot0(ack_in), 1);
        check("ack_excl_stage_req", (|ack_in) & stage_req, 0);
        if (ack_in != '0 && mon_prev_ack == '0) begin
          if (sb.size() == 0) begin
            check("unexpected_ack", ack_in, 0);
          end else begin
            mon_e = sb.pop_front();
            check("ack_bit",      ack_in,    32'(1) << mon_e.winner);
            check("grant_id",     grant_id,  mon_e.winner);
            check("stage_din",    stage_din, mon_e.din);
            check("res_out",      res_out,   mon_e.res);
            check("busy_in_resp", busy,      1);
            last_winner = mon_e.winner;
          end
        end
        if (ack_in == '0 && mon_prev_ack != '0) begin
          check("busy_after_ack", busy,     0);
          check("grant_id_hold",  grant_id, last_winner);
        end
        mon_prev_ack = ack_in;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    n_checks          = 0;
    n_fail            = 0;
    model_ptr         = N - 1;
    last_winner       = 0;
    stage_delay_fixed = -1;
    req_in            = '0;
    data_in           = '0;
    rst_n             = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single requester, 0x41 -> 0x42
    data_in[0 +: W] = 8'h41;
    req_in = 4'b0001;
    serve(1'b0, 1'b0, '0, 1'b0);

    // all four held and re-raised: 0,1,2,3,0,1 then drain
    pulse_reset();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = W'($urandom);
    req_in = 4'b1111;
    repeat (6) serve(1'b0, 1'b1, '0, 1'b0);
    while (req_in != '0) serve(1'b0, 1'b0, '0, 1'b0);

    // wrap boundary, 0xFF -> 0x00
    data_in[3*W +: W] = 8'hFF;
    req_in = 4'b1000;
    serve(1'b0, 1'b0, '0, 1'b0);
    data_in[0 +: W]   = 8'hFF;
    data_in[3*W +: W] = 8'hFF;
    req_in = 4'b1001;
    serve(1'b0, 1'b0, '0, 1'b0);
    serve(1'b0, 1'b0, '0, 1'b0);

    // late arrival of 2 while 1 is busy, 1's operand changed after grant
    data_in[1*W +: W] = 8'h5A;
    req_in = 4'b0010;
    serve(1'b1, 1'b0, 4'b0100, 1'b0);
    serve(1'b0, 1'b0, '0, 1'b0);

    // slow stage
    stage_delay_fixed = 20;
    data_in[0 +: W] = 8'h7F;
    req_in = 4'b0001;
    serve(1'b0, 1'b0, '0, 1'b0);
    stage_delay_fixed = -1;

    // requester drops early: one-clock ack pulse
    req_in = 4'b0100;
    serve(1'b0, 1'b0, '0, 1'b1);

    // reset while in ISSUE
    stage_delay_fixed = 20;
    req_in = 4'b1000;
    wait_busy(1'b1, "issue_busy");
    @(negedge clk);
    check("in_issue_stage_req", stage_req, 1);
    pulse_reset();
    stage_delay_fixed = -1;
    data_in[1*W +: W] = 8'h10;
    data_in[2*W +: W] = 8'h20;
    req_in = 4'b0110;
    serve(1'b0, 1'b0, '0, 1'b0);
    serve(1'b0, 1'b0, '0, 1'b0);

    // reset while in RESP
    req_in = 4'b0001;
    e.winner = rr_pick(model_ptr, req_in);
    e.din    = data_in[0 +: W];
    e.res    = e.din + W'(1);
    sb.push_back(e);
    wait_ack(1'b1, "resp_ack");
    pulse_reset();
    req_in = 4'b0110;
    serve(1'b0, 1'b0, '0, 1'b0);
    serve(1'b0, 1'b0, '0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if (req_in == '0) begin
        logic [N-1:0] m;
        m = N'($urandom_range(1, 15));
        for (int i = 0; i < N; i++)
          if ((m & (N'(1) << i)) != '0) data_in[i*W +: W] = W'($urandom);
        req_in = m;
      end
      serve(1'($urandom), 1'($urandom), N'($urandom), ($urandom % 8) == 0);
    end
    while (req_in != '0) serve(1'b0, 1'b0, '0, 1'b0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("final_idle_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
